// File: rtl/tetris_pkg.sv
// Shared playfield geometry, row type and line-clear FSM state encoding.
package tetris_pkg;

    localparam int GRID_COLS = 10;
    localparam int GRID_ROWS = 22;
    localparam int CELL_W    = 4;
    localparam int ROW_W     = GRID_COLS * CELL_W;
    localparam int ADDR_W    = 5;
    localparam int CNT_W     = 5;
    localparam int LC_TOT_W  = 16;

    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [ADDR_W-1:0] row_addr_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        EV   = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4
    } lc_state_t;

endpackage

// File: rtl/row_full_detect.sv
// Flags a row as full when every cell holds a nonzero colour code.
module row_full_detect
    import tetris_pkg::*;
(
    input  row_t row,
    output logic full
);

    always_comb begin
        full = 1'b1;
        for (int c = 0; c < GRID_COLS; c++) begin
            if (row[c*CELL_W +: CELL_W] == '0) begin
                full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/line_clear_ctrl.sv
// Bottom-up row scan that removes full rows, compacts survivors downward and
// zero-fills the vacated top rows, then reports the number of rows cleared.
module line_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int TOT_W = LC_TOT_W
) (
    input  logic             Clk,
    input  logic             reset_rtl_0,
    input  logic             start,
    input  logic             clr_total,
    output row_addr_t        row_rd_addr,
    input  row_t             row_rd_data,
    output logic             row_wr_en,
    output row_addr_t        row_wr_addr,
    output row_t             row_wr_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] lines_cleared,
    output logic [TOT_W-1:0] lines_total,
    output lc_state_t        dbg_state
);

    localparam row_addr_t LAST_ROW = row_addr_t'(GRID_ROWS - 1);

    // Handshake: start is a single-cycle request sampled only in IDLE; busy
    // covers the whole pass and done pulses for exactly one cycle at its end,
    // with lines_cleared/lines_total updated on the edge that closes DONE.

    lc_state_t        state, state_n;
    row_addr_t        rp, rp_n;
    row_addr_t        wp, wp_n;
    logic [CNT_W-1:0] count, count_n;
    logic             full;
    logic [TOT_W:0]   total_sum;

    row_full_detect u_full (
        .row  (row_rd_data),
        .full (full)
    );

    always_comb begin
        state_n     = state;
        rp_n        = rp;
        wp_n        = wp;
        count_n     = count;
        row_wr_en   = 1'b0;
        row_wr_data = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    rp_n    = LAST_ROW;
                    wp_n    = LAST_ROW;
                    count_n = '0;
                    state_n = RD;
                end
            end
            RD: state_n = EV;
            EV: begin
                if (full) begin
                    count_n = count + 1'b1;
                end else begin
                    // A survivor already at its final position needs no write.
                    if (rp != wp) begin
                        row_wr_en   = 1'b1;
                        row_wr_data = row_rd_data;
                    end
                    if (wp != '0) begin
                        wp_n = wp - 1'b1;
                    end
                end
                if (rp == '0) begin
                    state_n = (count_n != '0) ? FILL : DONE;
                end else begin
                    rp_n    = rp - 1'b1;
                    state_n = RD;
                end
            end
            FILL: begin
                row_wr_en = 1'b1;
                if (wp == '0) begin
                    state_n = DONE;
                end else begin
                    wp_n = wp - 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign row_rd_addr = rp;
    assign row_wr_addr = wp;
    assign busy        = (state == RD) || (state == EV) || (state == FILL);
    assign done        = (state == DONE);
    assign dbg_state   = state;
    assign total_sum   = {1'b0, lines_total} + {{(TOT_W + 1 - CNT_W){1'b0}}, count};

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            state         <= IDLE;
            rp            <= '0;
            wp            <= '0;
            count         <= '0;
            lines_cleared <= '0;
            lines_total   <= '0;
        end else begin
            state <= state_n;
            rp    <= rp_n;
            wp    <= wp_n;
            count <= count_n;
            if (state == DONE) begin
                lines_cleared <= count;
            end
            if (clr_total) begin
                lines_total <= '0;
            end else if (state == DONE) begin
                lines_total <= total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl with a registered-read grid model and an
// expected-value queue filled at each start and drained at each done.
module tb_line_clear_ctrl;
    import tetris_pkg::*;

    // Narrow running total so saturation is reachable in a short run.
    localparam int TW      = 8;
    localparam int TOT_MAX = (1 << TW) - 1;

    logic             Clk         = 1'b0;
    logic             reset_rtl_0 = 1'b0;
    logic             start       = 1'b0;
    logic             clr_total   = 1'b0;
    row_addr_t        row_rd_addr;
    row_t             row_rd_data;
    logic             row_wr_en;
    row_addr_t        row_wr_addr;
    row_t             row_wr_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] lines_cleared;
    logic [TW-1:0]    lines_total;
    lc_state_t        dbg_state;

    line_clear_ctrl #(.TOT_W(TW)) dut (
        .Clk           (Clk),
        .reset_rtl_0   (reset_rtl_0),
        .start         (start),
        .clr_total     (clr_total),
        .row_rd_addr   (row_rd_addr),
        .row_rd_data   (row_rd_data),
        .row_wr_en     (row_wr_en),
        .row_wr_addr   (row_wr_addr),
        .row_wr_data   (row_wr_data),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .lines_total   (lines_total),
        .dbg_state     (dbg_state)
    );

    always #5 Clk = ~Clk;

    // Grid storage with registered read; load copies load_img in one cycle.
    row_t grid     [GRID_ROWS];
    row_t load_img [GRID_ROWS];
    row_t exp_grid [GRID_ROWS];
    logic load     = 1'b0;
    int   wr_cnt   = 0;
    int   done_cnt = 0;

    always @(posedge Clk) begin
        row_rd_data <= grid[row_rd_addr];
        if (load) begin
            for (int i = 0; i < GRID_ROWS; i++) grid[i] <= load_img[i];
        end else if (row_wr_en) begin
            grid[row_wr_addr] <= row_wr_data;
        end
        if (row_wr_en) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    logic [15:0] exp_q[$];
    int n_checks  = 0;
    int n_fail    = 0;
    int exp_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pop_exp();
        if (exp_q.size() == 0) return 16'hDEAD;
        return exp_q.pop_front();
    endfunction

    function automatic row_t full_row();
        row_t r;
        for (int c = 0; c < GRID_COLS; c++) r[c*CELL_W +: CELL_W] = 4'($urandom_range(1, 15));
        return r;
    endfunction

    function automatic row_t sparse_row();
        row_t r;
        int   z;
        for (int c = 0; c < GRID_COLS; c++) r[c*CELL_W +: CELL_W] = 4'($urandom_range(0, 15));
        z = $urandom_range(0, GRID_COLS - 1);
        r[z*CELL_W +: CELL_W] = '0;
        return r;
    endfunction

    function automatic bit row_is_full(input row_t r);
        for (int c = 0; c < GRID_COLS; c++) begin
            if (r[c*CELL_W +: CELL_W] == '0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference: keep non-full rows in bottom-up order, stack them from the bottom.
    task automatic build_expect(output int n_full, output int n_wr);
        int dst;
        dst    = GRID_ROWS - 1;
        n_full = 0;
        n_wr   = 0;
        for (int r = GRID_ROWS - 1; r >= 0; r--) begin
            if (row_is_full(load_img[r])) begin
                n_full++;
            end else begin
                exp_grid[dst] = load_img[r];
                if (dst != r) n_wr++;
                dst--;
            end
        end
        for (int r = dst; r >= 0; r--) exp_grid[r] = '0;
        n_wr += n_full;
    endtask

    task automatic load_grid();
        @(negedge Clk) load = 1'b1;
        @(negedge Clk) load = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int restart_at, input bit clr_at_done);
        int n_full, n_wr, lat, w0, d0, bad;
        build_expect(n_full, n_wr);
        exp_q.push_back(16'(2 * GRID_ROWS + n_full + 1));
        exp_q.push_back(16'(n_full));
        if (clr_at_done) exp_total = 0;
        else exp_total = (exp_total + n_full > TOT_MAX) ? TOT_MAX : exp_total + n_full;
        exp_q.push_back(16'(exp_total));
        exp_q.push_back(16'(n_wr));
        load_grid();
        w0 = wr_cnt;
        d0 = done_cnt;
        @(negedge Clk) start = 1'b1;
        @(negedge Clk) start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge Clk);
            lat++;
            start = (lat == restart_at);
        end
        start = 1'b0;
        check({tag, " done seen"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(pop_exp()));
        clr_total = clr_at_done;
        @(negedge Clk);
        clr_total = 1'b0;
        check({tag, " lines_cleared"}, 32'(lines_cleared), 32'(pop_exp()));
        check({tag, " lines_total"}, 32'(lines_total), 32'(pop_exp()));
        check({tag, " writes"}, 32'(wr_cnt - w0), 32'(pop_exp()));
        check({tag, " done pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        bad = 0;
        for (int r = 0; r < GRID_ROWS; r++) if (grid[r] !== exp_grid[r]) bad++;
        check({tag, " grid rows wrong"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int w0, d0, lat;

        for (int r = 0; r < GRID_ROWS; r++) load_img[r] = '0;
        repeat (3) @(negedge Clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst wr_en", 32'(row_wr_en), 32'd0);
        check("rst rd_addr", 32'(row_rd_addr), 32'd0);
        check("rst wr_addr", 32'(row_wr_addr), 32'd0);
        check("rst wr_data", 32'(row_wr_data), 32'd0);
        check("rst lines_cleared", 32'(lines_cleared), 32'd0);
        check("rst lines_total", 32'(lines_total), 32'd0);
        check("rst state", 32'(dbg_state), 32'(IDLE));
        reset_rtl_0 = 1'b1;

        run_pass("empty", 0, 1'b0);

        load_img[GRID_ROWS-1] = full_row();
        load_img[GRID_ROWS-2] = '0;
        load_img[GRID_ROWS-2][CELL_W-1:0] = 4'd3;
        run_pass("one_full", 0, 1'b0);

        for (int r = 0; r < GRID_ROWS; r++) load_img[r] = sparse_row();
        load_img[21] = full_row();
        load_img[19] = full_row();
        load_img[17] = full_row();
        load_img[15] = full_row();
        run_pass("four_full", 0, 1'b0);

        for (int r = 0; r < GRID_ROWS; r++) load_img[r] = full_row();
        run_pass("all_full", 0, 1'b0);

        for (int r = 0; r < GRID_ROWS; r++)
            load_img[r] = ($urandom_range(0, 2) == 0) ? full_row() : sparse_row();
        run_pass("random", 0, 1'b0);

        for (int r = 0; r < GRID_ROWS; r++)
            load_img[r] = ($urandom_range(0, 1) == 0) ? full_row() : sparse_row();
        run_pass("restart", 10, 1'b0);
        w0 = wr_cnt;
        d0 = done_cnt;
        repeat (50) @(negedge Clk);
        check("restart no second pass writes", 32'(wr_cnt - w0), 32'd0);
        check("restart no second done", 32'(done_cnt - d0), 32'd0);

        // Abort a pass with reset while compaction writes are in flight.
        for (int r = 0; r < GRID_ROWS; r++) load_img[r] = (r % 2 == 1) ? full_row() : sparse_row();
        load_grid();
        @(negedge Clk) start = 1'b1;
        @(negedge Clk) start = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        reset_rtl_0 = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort wr_en", 32'(row_wr_en), 32'd0);
        check("abort lines_cleared", 32'(lines_cleared), 32'd0);
        check("abort lines_total", 32'(lines_total), 32'd0);
        check("abort state", 32'(dbg_state), 32'(IDLE));
        exp_total = 0;
        w0 = wr_cnt;
        d0 = done_cnt;
        repeat (2) @(negedge Clk);
        reset_rtl_0 = 1'b1;
        repeat (60) @(negedge Clk);
        check("abort no writes", 32'(wr_cnt - w0), 32'd0);
        check("abort no done", 32'(done_cnt - d0), 32'd0);

        for (int r = 0; r < GRID_ROWS; r++) load_img[r] = full_row();
        run_pass("sat_pre", 0, 1'b0);
        run_pass("clr_at_done", 0, 1'b1);
        for (int p = 0; p < 13; p++) run_pass($sformatf("sat_%0d", p), 0, 1'b0);
        check("saturated total", 32'(lines_total), 32'(TOT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
